acc_router_n: RTL and testbench

ACC_ROUTER_N -- requirements
Module: acc_router_n

---
 rtl/acc_router_pkg.sv | 25 ++
 rtl/acc_ch_mux.sv | 61 ++++++
 rtl/acc_router_n.sv | 210 +++++++++++++++++++++
 tb/tb_acc_router_n.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_router_pkg.sv
// Shared definitions for the accelerator router: FSM state encoding,
// default parameter values and the channel-select width helper.
// No logic; imported by acc_router_n and acc_ch_mux.
package acc_router_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_N_CH   = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_PUT  = 3'd3,
        ST_GET  = 3'd4,
        ST_WR   = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    // A single channel still needs a 1-bit select port.
    function automatic int sel_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/acc_ch_mux.sv
// Channel steering: one-hot demux of push/pop strobes and push data, mux of pop data/status.
// Latency: purely combinational, zero cycles.
// Backpressure: exposes the selected channel's to_full/from_empty; an unmatched select reads as full/empty.
// Ports: sel (channel index), put_en/get_en/drive_dat (strobes from the FSM), put_dat (push word),
//        to_full/from_empty/ch_data_in (per-channel FIFO side), put_req/get_req/ch_data_out (per-channel),
//        sel_full/sel_empty/get_dat (selected-channel view).
module acc_ch_mux
    import acc_router_pkg::*;
#(
    parameter int N_CH   = DEF_N_CH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int SEL_W  = 2
) (
    input  logic [SEL_W-1:0]       sel,
    input  logic                   put_en,
    input  logic                   get_en,
    input  logic                   drive_dat,
    input  logic [DATA_W-1:0]      put_dat,
    input  logic [N_CH-1:0]        to_full,
    input  logic [N_CH-1:0]        from_empty,
    input  logic [N_CH*DATA_W-1:0] ch_data_in,
    output logic [N_CH-1:0]        put_req,
    output logic [N_CH-1:0]        get_req,
    output logic [N_CH*DATA_W-1:0] ch_data_out,
    output logic                   sel_full,
    output logic                   sel_empty,
    output logic [DATA_W-1:0]      get_dat
);

    // Selected-channel view. Kept separate from the demux so the FSM's
    // strobes (which depend on sel_full/sel_empty) do not form a false loop.
    always_comb begin
        sel_full  = 1'b1;
        sel_empty = 1'b1;
        get_dat   = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_full  = to_full[k];
                sel_empty = from_empty[k];
                get_dat   = ch_data_in[k*DATA_W +: DATA_W];
            end
        end
    end

    // Demux: only the selected channel ever sees a strobe or non-zero data.
    always_comb begin
        put_req     = '0;
        get_req     = '0;
        ch_data_out = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel == SEL_W'(k)) begin
                put_req[k] = put_en;
                get_req[k] = get_en;
                if (drive_dat) begin
                    ch_data_out[k*DATA_W +: DATA_W] = put_dat;
                end
            end
        end
    end

endmodule

// File: rtl/acc_router_n.sv
// Job engine: copies filesize words RAM->accelerator channel, then channel->RAM at the same addresses.
// Latency: 3 cycles/word inbound (RD,CAP,PUT), 2 cycles/word outbound (GET,WR), plus start and DONE cycles.
// Backpressure: waits in PUT while to_full[sel], in GET while from_empty[sel]; start ignored while busy.
// Ports: clk, reset (sync, active-low); job inputs start/acc_bypass/chan_sel/offset/filesize;
//        status busy/acc_done/sel_err/stall_cnt; channel side ch_enable/put_req/get_req/to_full/from_empty/
//        ch_data_out/ch_data_in; RAM side ram_read_enable/ram_write_enable/addr/ram_rdata/ram_wdata.
// Option: define ACC_ROUTER_STALL_CNT_EN to build the saturating stall counter; otherwise stall_cnt is 0.
module acc_router_n
    import acc_router_pkg::*;
#(
    parameter int  DATA_W = DEF_DATA_W,
    parameter int  ADDR_W = DEF_ADDR_W,
    parameter int  N_CH   = DEF_N_CH,
    localparam int SEL_W  = sel_width(N_CH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   acc_bypass,
    input  logic [SEL_W-1:0]       chan_sel,
    input  logic [ADDR_W-1:0]      offset,
    input  logic [ADDR_W-1:0]      filesize,
    output logic                   busy,
    output logic                   acc_done,
    output logic                   sel_err,
    output logic [N_CH-1:0]        ch_enable,
    output logic [N_CH-1:0]        put_req,
    output logic [N_CH-1:0]        get_req,
    input  logic [N_CH-1:0]        to_full,
    input  logic [N_CH-1:0]        from_empty,
    output logic [N_CH*DATA_W-1:0] ch_data_out,
    input  logic [N_CH*DATA_W-1:0] ch_data_in,
    output logic                   ram_read_enable,
    output logic                   ram_write_enable,
    output logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      ram_rdata,
    output logic [DATA_W-1:0]      ram_wdata,
    output logic [31:0]            stall_cnt
);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [ADDR_W-1:0] off_q, off_d;
    logic [ADDR_W-1:0] size_q, size_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              skip_q, skip_d;   // job does no transfers (bypass, empty or bad channel)
    logic              err_q, err_d;

    logic              put_en, get_en, rd_en, wr_en;
    logic              sel_full, sel_empty, sel_bad, last_word, job_accept, skip_in;
    logic [DATA_W-1:0] get_dat;

    assign sel_bad    = 32'(chan_sel) >= 32'(N_CH);
    assign skip_in    = acc_bypass || (filesize == '0) || sel_bad;
    assign last_word  = (cnt_q == size_q - ADDR_W'(1));
    assign job_accept = (state_q == ST_IDLE) && start;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        off_d   = off_q;
        size_d  = size_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        skip_d  = skip_q;
        err_d   = err_q;
        put_en  = 1'b0;
        get_en  = 1'b0;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sel_d   = chan_sel;
                    off_d   = offset;
                    size_d  = filesize;
                    cnt_d   = '0;
                    err_d   = sel_bad;
                    skip_d  = skip_in;
                    state_d = skip_in ? ST_DONE : ST_RD;
                end
            end
            ST_RD: begin
                rd_en   = 1'b1;
                state_d = ST_CAP;
            end
            ST_CAP: begin
                hold_d  = ram_rdata;
                state_d = ST_PUT;
            end
            ST_PUT: begin
                if (!sel_full) begin
                    put_en = 1'b1;
                    // Outbound phase re-walks the same addresses from zero.
                    if (last_word) begin
                        cnt_d   = '0;
                        state_d = ST_GET;
                    end else begin
                        cnt_d   = cnt_q + ADDR_W'(1);
                        state_d = ST_RD;
                    end
                end
            end
            ST_GET: begin
                if (!sel_empty) begin
                    get_en  = 1'b1;
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                // Pop data arrives one cycle after get_req, i.e. now.
                wr_en   = 1'b1;
                cnt_d   = cnt_q + ADDR_W'(1);
                state_d = last_word ? ST_DONE : ST_GET;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            skip_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            off_q   <= off_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            skip_q  <= skip_d;
            err_q   <= err_d;
        end
    end

    acc_ch_mux #(
        .N_CH   (N_CH),
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) u_mux (
        .sel         (sel_q),
        .put_en      (put_en),
        .get_en      (get_en),
        .drive_dat   (state_q == ST_PUT),
        .put_dat     (hold_q),
        .to_full     (to_full),
        .from_empty  (from_empty),
        .ch_data_in  (ch_data_in),
        .put_req     (put_req),
        .get_req     (get_req),
        .ch_data_out (ch_data_out),
        .sel_full    (sel_full),
        .sel_empty   (sel_empty),
        .get_dat     (get_dat)
    );

    assign busy             = (state_q != ST_IDLE);
    assign acc_done         = (state_q == ST_DONE);
    assign sel_err          = acc_done && err_q;
    assign ram_read_enable  = rd_en;
    assign ram_write_enable = wr_en;
    assign addr             = (rd_en || wr_en) ? (off_q + cnt_q) : '0;
    assign ram_wdata        = wr_en ? get_dat : '0;

    always_comb begin
        ch_enable = '0;
        for (int k = 0; k < N_CH; k++) begin
            ch_enable[k] = busy && !skip_q && (sel_q == SEL_W'(k));
        end
    end

`ifdef ACC_ROUTER_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (job_accept) begin
            stall_d = '0;
        end else if ((((state_q == ST_PUT) && sel_full) || ((state_q == ST_GET) && sel_empty))
                     && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_acc_router_n.sv
// Bench for acc_router_n: table of directed jobs, random jobs against a queue-based model,
// plus hand-written stall and mid-job reset sequences.
module tb_acc_router_n;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int N_CH   = 3;
    localparam int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [31:0] XORC = 32'hFFFF_0000;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   start = 1'b0;
    logic                   acc_bypass = 1'b0;
    logic [SEL_W-1:0]       chan_sel = '0;
    logic [ADDR_W-1:0]      offset = '0;
    logic [ADDR_W-1:0]      filesize = '0;
    logic                   busy, acc_done, sel_err;
    logic [N_CH-1:0]        ch_enable, put_req, get_req;
    logic [N_CH-1:0]        to_full = '0;
    logic [N_CH-1:0]        from_empty = '0;
    logic [N_CH*DATA_W-1:0] ch_data_out;
    logic [N_CH*DATA_W-1:0] ch_data_in = '0;
    logic                   ram_read_enable, ram_write_enable;
    logic [ADDR_W-1:0]      addr;
    logic [DATA_W-1:0]      ram_rdata = '0;
    logic [DATA_W-1:0]      ram_wdata;
    logic [31:0]            stall_cnt;

    acc_router_n #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_CH(N_CH)) dut (
        .clk(clk), .reset(reset), .start(start), .acc_bypass(acc_bypass),
        .chan_sel(chan_sel), .offset(offset), .filesize(filesize),
        .busy(busy), .acc_done(acc_done), .sel_err(sel_err), .ch_enable(ch_enable),
        .put_req(put_req), .get_req(get_req), .to_full(to_full), .from_empty(from_empty),
        .ch_data_out(ch_data_out), .ch_data_in(ch_data_in),
        .ram_read_enable(ram_read_enable), .ram_write_enable(ram_write_enable),
        .addr(addr), .ram_rdata(ram_rdata), .ram_wdata(ram_wdata), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM contents as a plain function of address.
    function automatic logic [31:0] ram_val(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0135_7BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Observation log filled by the monitor.
    logic [31:0]     rd_q[$], put_q[$], wra_q[$], wrd_q[$], acc_q[$];
    int              done_cnt, done_cyc, err_cnt, viol, get_cnt;
    int              cur_sel = 0;
    logic [N_CH-1:0] cur_en = '0;
    int              stall_mode = 0;
    int              start_cyc = 0;
    int              rel;

    // Monitor + RAM/accelerator responders, sampled mid-cycle.
    always @(negedge clk) begin
        logic [N_CH-1:0] en_exp;
        en_exp = busy ? cur_en : '0;
        if (ch_enable !== en_exp) viol++;
        if (ram_read_enable && ram_write_enable) viol++;
        if (!ram_read_enable && !ram_write_enable && (addr !== '0 || ram_wdata !== '0)) viol++;
        if (sel_err && !acc_done) viol++;
        if (!busy && (put_req !== '0 || get_req !== '0 || ram_read_enable || ram_write_enable)) viol++;
        if (ram_read_enable) begin
            rd_q.push_back(addr);
            ram_rdata = ram_val(addr);
        end
        if (ram_write_enable) begin
            wra_q.push_back(addr);
            wrd_q.push_back(ram_wdata);
        end
        for (int k = 0; k < N_CH; k++) begin
            if (k != cur_sel) begin
                if (put_req[k] || get_req[k] || ch_data_out[k*DATA_W +: DATA_W] !== '0) viol++;
            end
            if (put_req[k]) begin
                if (to_full[k]) viol++;
                put_q.push_back(ch_data_out[k*DATA_W +: DATA_W]);
                acc_q.push_back(ch_data_out[k*DATA_W +: DATA_W]);
            end
            if (get_req[k]) begin
                if (from_empty[k]) viol++;
                get_cnt++;
                if (acc_q.size() > 0) ch_data_in[k*DATA_W +: DATA_W] = acc_q.pop_front() ^ XORC;
            end
        end
        if (acc_done) begin
            done_cnt++;
            done_cyc = cyc;
            if (sel_err) err_cnt++;
        end
    end

    // Flow-control driver: 0 none, 1 random, 2 fixed windows on channel 1.
    always @(posedge clk) begin
        #2;
        case (stall_mode)
            1: begin
                to_full    = N_CH'($urandom) & N_CH'($urandom);
                from_empty = N_CH'($urandom) & N_CH'($urandom);
            end
            2: begin
                rel        = cyc - start_cyc;
                to_full    = (rel >= 1 && rel <= 7)  ? N_CH'(2) : '0;
                from_empty = (rel >= 1 && rel <= 20) ? N_CH'(2) : '0;
            end
            default: begin
                to_full    = '0;
                from_empty = '0;
            end
        endcase
    end

    task automatic clear_log();
        rd_q.delete(); put_q.delete(); wra_q.delete(); wrd_q.delete(); acc_q.delete();
        done_cnt = 0; err_cnt = 0; viol = 0; get_cnt = 0; done_cyc = 0;
    endtask

    task automatic launch(input logic byp, input int sel, input logic [31:0] off, input logic [31:0] n);
        @(posedge clk); #1;
        start = 1'b1; acc_bypass = byp; chan_sel = SEL_W'(sel); offset = off; filesize = n;
        start_cyc = cyc;
        @(posedge clk); #1;
        // Scrambled inputs with start still high: must not affect the running job.
        acc_bypass = 1'($urandom); chan_sel = SEL_W'($urandom); offset = $urandom; filesize = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Runs one job and checks it against the model. exact=0 means exp_lat is a lower bound.
    task automatic run_job(input string tag, input logic byp, input int sel, input logic [31:0] off,
                           input logic [31:0] n, input int mode, input int exp_lat,
                           input logic exp_err, input logic exact, input int exp_stall);
        logic skip;
        int   lat, nw;
        skip = byp || (n == 0) || (sel >= N_CH);
        nw   = skip ? 0 : int'(n);
        clear_log();
        cur_sel    = sel;
        cur_en     = skip ? '0 : (N_CH'(1) << sel);
        stall_mode = mode;
        launch(byp, sel, off, n);
        for (int i = 0; i < 600 && done_cnt == 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        lat = done_cyc - start_cyc;
        chk({tag, " done_cnt"}, done_cnt, 1);
        if (exact) chk({tag, " latency"}, lat, exp_lat);
        else       chk({tag, " latency_min"}, 32'(lat >= exp_lat), 1);
        chk({tag, " sel_err"}, err_cnt, 32'(exp_err));
        chk({tag, " reads"}, rd_q.size(), nw);
        chk({tag, " puts"}, put_q.size(), nw);
        chk({tag, " gets"}, get_cnt, nw);
        chk({tag, " writes"}, wra_q.size(), nw);
        for (int i = 0; i < nw && i < rd_q.size() && i < put_q.size() && i < wra_q.size(); i++) begin
            chk({tag, " rd_addr"}, rd_q[i], off + 32'(i));
            chk({tag, " put_dat"}, put_q[i], ram_val(off + 32'(i)));
            chk({tag, " wr_addr"}, wra_q[i], off + 32'(i));
            chk({tag, " wr_dat"}, wrd_q[i], ram_val(off + 32'(i)) ^ XORC);
        end
        chk({tag, " protocol"}, viol, 0);
        chk({tag, " busy_after"}, 32'(busy), 0);
`ifdef ACC_ROUTER_STALL_CNT_EN
        if (exp_stall < 0) chk({tag, " stall_cnt"}, stall_cnt, skip ? 0 : 32'(lat - exp_lat));
        else               chk({tag, " stall_cnt"}, stall_cnt, exp_stall);
`else
        chk({tag, " stall_cnt"}, stall_cnt, 0);
`endif
        stall_mode = 0;
    endtask

    typedef struct {
        string       tag;
        logic        byp;
        int          sel;
        logic [31:0] off;
        logic [31:0] n;
        int          exp_lat;
        logic        exp_err;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{"basic",   1'b0, 1, 32'h0000_0100, 32'd4, 21, 1'b0};
        tbl[1] = '{"bypass",  1'b1, 1, 32'h0000_0100, 32'd4, 1,  1'b0};
        tbl[2] = '{"bad_sel", 1'b0, 3, 32'h0000_0100, 32'd4, 1,  1'b1};
        tbl[3] = '{"zero_len",1'b0, 2, 32'h0000_0040, 32'd0, 1,  1'b0};
        tbl[4] = '{"wrap",    1'b0, 1, 32'hFFFF_FFFE, 32'd4, 21, 1'b0};
        tbl[5] = '{"one_word",1'b0, 0, 32'h0000_2000, 32'd1, 6,  1'b0};
        tbl[6] = '{"seven",   1'b0, 2, 32'h0000_0300, 32'd7, 36, 1'b0};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst busy", 32'(busy), 0);
        chk("rst strobes", 32'({acc_done, sel_err, ram_read_enable, ram_write_enable}), 0);
        chk("rst chan", 32'({ch_enable, put_req, get_req}), 0);
        chk("rst addr", addr, 0);
        chk("rst wdata", ram_wdata, 0);
        chk("rst stall_cnt", stall_cnt, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        foreach (tbl[i])
            run_job(tbl[i].tag, tbl[i].byp, tbl[i].sel, tbl[i].off, tbl[i].n, 0,
                    tbl[i].exp_lat, tbl[i].exp_err, 1'b1, 0);

        // Random jobs against the model.
        for (int j = 0; j < 14; j++) begin
            logic        byp;
            int          sel, mode, lat;
            logic [31:0] off, n;
            logic        skip;
            byp  = ($urandom_range(0, 7) == 0);
            sel  = $urandom_range(0, N_CH);
            off  = $urandom;
            n    = $urandom_range(0, 6);
            mode = $urandom_range(0, 1);
            skip = byp || (n == 0) || (sel >= N_CH);
            lat  = skip ? 1 : 5 * int'(n) + 1;
            run_job("rand", byp, sel, off, n, mode, lat, 1'(sel >= N_CH),
                    1'(skip || mode == 0), (skip || mode == 0) ? 0 : -1);
        end

        // Channel 1 full for 5 PUT cycles of word 0, empty for 3 GET cycles of word 0.
        run_job("stall", 1'b0, 1, 32'h0000_0500, 32'd4, 2, 29, 1'b0, 1'b1, 8);

        // Reset for one edge during GET of the second outbound word.
        clear_log();
        cur_sel = 1; cur_en = N_CH'(2); stall_mode = 0;
        launch(1'b0, 1, 32'h0000_0700, 32'd4);
        for (int i = 0; i < 100 && cyc < start_cyc + 15; i++) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        cur_en = '0;
        @(negedge clk);
        chk("abort gets_before", get_cnt, 2);
        chk("abort busy", 32'(busy), 0);
        chk("abort strobes", 32'({acc_done, sel_err, ram_read_enable, ram_write_enable}), 0);
        chk("abort chan", 32'({ch_enable, put_req, get_req}), 0);
        chk("abort addr", addr, 0);
        chk("abort wdata", ram_wdata, 0);
        chk("abort data_out", 32'(ch_data_out != '0), 0);
        chk("abort stall_cnt", stall_cnt, 0);
        repeat (30) @(negedge clk);
        chk("abort no_done", done_cnt, 0);
        run_job("after_abort", 1'b0, 1, 32'h0000_0100, 32'd4, 0, 21, 1'b0, 1'b1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
